// File: rtl/dmem_responder_pkg.sv
// ----------------------------------------------------------------------------
// dmem_pkg
//   Shared types and helpers for the data-memory responder.
//   - host_state_t : host request/response FSM states
//   - dmem_dec_t   : result of an address decode (in-range/aligned flag plus
//                    the full-width word index; users slice the low bits)
//   - dmem_decode  : byte address -> {ok, word index}
// ----------------------------------------------------------------------------
package dmem_pkg;

    localparam int WORD_BYTES = 8;

    typedef enum logic {
        H_IDLE,
        H_RESP
    } host_state_t;

    typedef struct packed {
        logic        ok;
        logic [63:0] idx;
    } dmem_dec_t;

    // The offset is taken modulo 2^64, so an address below base wraps to a
    // huge offset and fails the unsigned range compare.
    function automatic dmem_dec_t dmem_decode(input logic [63:0] addr,
                                              input logic [63:0] base,
                                              input logic [63:0] depth);
        logic [63:0] off;
        dmem_dec_t   d;
        off   = addr - base;
        d.ok  = (off[2:0] == 3'b000) && (off < (depth << 3));
        d.idx = off >> 3;
        return d;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// ----------------------------------------------------------------------------
// dmem_responder_if
//   Bundles the core data-memory bus and the secondary host request/response
//   channel of the data-memory responder.
//   Core side : data_mem_addr/wdata/we (in), data_mem_rdata (out), core_err
//   Host side : h_req_valid/we/addr/wdata (in), h_req_ready (out),
//               h_rsp_valid/rdata/err (out), h_rsp_ready (in)
//   modport master : the core + host initiators
//   modport slave  : the memory responder
// ----------------------------------------------------------------------------
interface dmem_responder_if;

    logic [63:0] data_mem_addr;
    logic [63:0] data_mem_wdata;
    logic        data_mem_we;
    logic [63:0] data_mem_rdata;
    logic        core_err;

    logic        h_req_valid;
    logic        h_req_ready;
    logic        h_req_we;
    logic [63:0] h_req_addr;
    logic [63:0] h_req_wdata;
    logic        h_rsp_valid;
    logic        h_rsp_ready;
    logic [63:0] h_rsp_rdata;
    logic        h_rsp_err;

    modport master (
        output data_mem_addr, data_mem_wdata, data_mem_we,
        input  data_mem_rdata, core_err,
        output h_req_valid, h_req_we, h_req_addr, h_req_wdata, h_rsp_ready,
        input  h_req_ready, h_rsp_valid, h_rsp_rdata, h_rsp_err
    );

    modport slave (
        input  data_mem_addr, data_mem_wdata, data_mem_we,
        output data_mem_rdata, core_err,
        input  h_req_valid, h_req_we, h_req_addr, h_req_wdata, h_rsp_ready,
        output h_req_ready, h_rsp_valid, h_rsp_rdata, h_rsp_err
    );

endinterface

// File: rtl/dmem_responder_host_port.sv
// ----------------------------------------------------------------------------
// dmem_host_port
//   Host request/response sequencer for the data-memory responder.
//   Two-state FSM: IDLE accepts one request, RESP holds the registered
//   response until the host consumes it.
//   Ports:
//     clk, rst_n     clock / async active-low reset
//     req_valid      host request valid
//     req_we         host request is a write
//     core_we        core is writing this cycle (owns the write port)
//     addr_ok        host address decoded in range and aligned
//     rd_data        current memory read value at the host address
//     rsp_ready      host consumes the response
//     req_ready      request accepted if valid
//     accept         request handshake completes this cycle
//     rsp_valid      response valid
//     rsp_rdata      registered read data (0 for writes / errors)
//     rsp_err        registered error flag
// ----------------------------------------------------------------------------
module dmem_host_port
    import dmem_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic        core_we,
    input  logic        addr_ok,
    input  logic [63:0] rd_data,
    input  logic        rsp_ready,
    output logic        req_ready,
    output logic        accept,
    output logic        rsp_valid,
    output logic [63:0] rsp_rdata,
    output logic        rsp_err
);

    host_state_t state, state_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= H_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The core always wins the single write port, so the host is only
    // offered ready in IDLE while the core is not storing.
    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        accept    = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            H_IDLE: begin
                req_ready = !core_we;
                accept    = req_valid && !core_we;
                if (accept) begin
                    state_nxt = H_RESP;
                end
            end
            H_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = H_IDLE;
                end
            end
            default: state_nxt = H_IDLE;
        endcase
    end

    // Response registers load only on accept, which keeps them stable for
    // the whole RESP phase regardless of later memory traffic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else if (accept) begin
            rsp_rdata <= (!req_we && addr_ok) ? rd_data : '0;
            rsp_err   <= !addr_ok;
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// ----------------------------------------------------------------------------
// dmem_responder
//   Memory end of the core data-memory interface plus a host loader/debug
//   port. Core reads are combinational, writes land on the clock edge.
//   Per-word valid bits make reset behave as a zero-fill of the array.
//   Parameters:
//     DEPTH      number of 64-bit words (power of 2, >= 2)
//     BASE_ADDR  byte address of word 0
//   Ports:
//     clk        clock, rising edge
//     rst_n      asynchronous active-low reset
//     bus        dmem_responder_if.slave (core bus, host channel, core_err)
// ----------------------------------------------------------------------------
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          DEPTH     = 512,
    parameter logic [63:0] BASE_ADDR = 64'h0
) (
    input  logic              clk,
    input  logic              rst_n,
    dmem_responder_if.slave   bus
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [63:0]      mem [DEPTH];
    logic [DEPTH-1:0] vld;

    dmem_dec_t        c_dec;
    dmem_dec_t        h_dec;
    logic [IDX_W-1:0] c_idx;
    logic [IDX_W-1:0] h_idx;
    logic [63:0]      h_rd;
    logic             h_accept;

    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    logic [63:0]      wr_data;

    logic             core_err_q;

    assign c_dec = dmem_decode(bus.data_mem_addr, BASE_ADDR, 64'(DEPTH));
    assign h_dec = dmem_decode(bus.h_req_addr,    BASE_ADDR, 64'(DEPTH));
    assign c_idx = c_dec.idx[IDX_W-1:0];
    assign h_idx = h_dec.idx[IDX_W-1:0];

    // Upper index bits are already covered by the range check in ok.
    logic unused_idx_hi;
    assign unused_idx_hi = ^{c_dec.idx[63:IDX_W], h_dec.idx[63:IDX_W]};

    // Words never written since reset read as zero.
    assign bus.data_mem_rdata = (c_dec.ok && vld[c_idx]) ? mem[c_idx] : '0;
    assign h_rd               = (h_dec.ok && vld[h_idx]) ? mem[h_idx] : '0;

    // Single write port: a host write can only be accepted when the core is
    // not storing, so the two sources never collide here.
    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = '0;
        wr_data = '0;
        if (bus.data_mem_we && c_dec.ok) begin
            wr_en   = 1'b1;
            wr_idx  = c_idx;
            wr_data = bus.data_mem_wdata;
        end else if (h_accept && bus.h_req_we && h_dec.ok) begin
            wr_en   = 1'b1;
            wr_idx  = h_idx;
            wr_data = bus.h_req_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
        end else if (wr_en) begin
            vld[wr_idx] <= 1'b1;
        end
    end

    // The core has no read strobe, so every cycle is an access: any cycle
    // with a bad core address latches the sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_err_q <= 1'b0;
        end else if (!c_dec.ok) begin
            core_err_q <= 1'b1;
        end
    end

    assign bus.core_err = core_err_q;

    dmem_host_port u_host_port (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (bus.h_req_valid),
        .req_we    (bus.h_req_we),
        .core_we   (bus.data_mem_we),
        .addr_ok   (h_dec.ok),
        .rd_data   (h_rd),
        .rsp_ready (bus.h_rsp_ready),
        .req_ready (bus.h_req_ready),
        .accept    (h_accept),
        .rsp_valid (bus.h_rsp_valid),
        .rsp_rdata (bus.h_rsp_rdata),
        .rsp_err   (bus.h_rsp_err)
    );

endmodule
